// File: rtl/cache_arbiter_if.sv
// Line-fill bus bundle between the two L1 clients, the arbiter and the next memory level.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 256
);
  logic [31:0]           i_pmem_address;
  logic                  i_pmem_read;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic [31:0]           d_pmem_address;
  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic [31:0]           l2_address;
  logic                  l2_read;
  logic                  l2_write;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;

  logic                  conflict_clear;
  logic [31:0]           conflict_count;

  modport slave (
    input  i_pmem_address, i_pmem_read,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output l2_address, l2_read, l2_write, l2_wdata,
    input  l2_rdata, l2_resp,
    input  conflict_clear,
    output conflict_count
  );

  modport master (
    output i_pmem_address, i_pmem_read,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  l2_address, l2_read, l2_write, l2_wdata,
    output l2_rdata, l2_resp,
    output conflict_clear,
    input  conflict_count
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serialising L1I/L1D line fills and writebacks onto one downstream port,
// with a saturating counter of arbitrations where both clients were waiting.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic                  op_write_q, op_write_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]           conflict_count_q, conflict_count_d;
  logic                  i_req_s;
  logic                  d_req_s;
  logic                  conflict_s;

  assign i_req_s    = bus.i_pmem_read;
  assign d_req_s    = bus.d_pmem_read | bus.d_pmem_write;
  assign conflict_s = (state_q == IDLE) & i_req_s & d_req_s;

  // Grant decision and request latching; last_d_q=1 means D won the previous arbitration.
  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (d_req_s && (!i_req_s || !last_d_q)) begin
          state_d    = SERVE_D;
          last_d_d   = 1'b1;
          addr_d     = bus.d_pmem_address;
          wdata_d    = bus.d_pmem_wdata;
          op_write_d = bus.d_pmem_write;
        end else if (i_req_s) begin
          state_d    = SERVE_I;
          last_d_d   = 1'b0;
          addr_d     = bus.i_pmem_address;
          op_write_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.l2_resp) begin
          state_d = DONE;
        end else begin
          state_d = state_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conflict counter: clear beats increment, increment saturates at all-ones.
  always_comb begin
    conflict_count_d = conflict_count_q;
    if (bus.conflict_clear) begin
      conflict_count_d = 32'd0;
    end else if (conflict_s && (conflict_count_q != 32'hFFFF_FFFF)) begin
      conflict_count_d = conflict_count_q + 32'd1;
    end else begin
      conflict_count_d = conflict_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      last_d_q         <= 1'b0;
      op_write_q       <= 1'b0;
      addr_q           <= 32'd0;
      wdata_q          <= {LINE_WIDTH{1'b0}};
      conflict_count_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      last_d_q         <= last_d_d;
      op_write_q       <= op_write_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  // Downstream strobes come straight from registered state, so they drop in DONE and on reset.
  assign bus.l2_address     = addr_q;
  assign bus.l2_wdata       = wdata_q;
  assign bus.l2_read        = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~op_write_q);
  assign bus.l2_write       = (state_q == SERVE_D) & op_write_q;
  assign bus.i_pmem_resp    = (state_q == SERVE_I) & bus.l2_resp;
  assign bus.d_pmem_resp    = (state_q == SERVE_D) & bus.l2_resp;
  assign bus.i_pmem_rdata   = bus.l2_rdata;
  assign bus.d_pmem_rdata   = bus.l2_rdata;
  assign bus.conflict_count = conflict_count_q;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-client arbiter that responds to the L1 instruction cache and the L1 data cache on their 256-bit line-fill interfaces. It initiates one request at a time to the next memory level (L2/physical memory) on the same protocol. It serialises concurrent misses with round-robin priority, latches the winning request, forwards the downstream response to the winner, and counts arbitration conflicts for performance monitoring.

## Interface
- LINE_WIDTH, 256, cache line width in bits for all data buses
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_pmem_address  in  32  L1I line address
- i_pmem_read  in  1  L1I read request, held high until i_pmem_resp
- i_pmem_rdata  out  LINE_WIDTH  line data to L1I
- i_pmem_resp  out  1  one-cycle completion pulse to L1I
- d_pmem_address  in  32  L1D line address
- d_pmem_read  in  1  L1D read request, held until d_pmem_resp
- d_pmem_write  in  1  L1D writeback request, held until d_pmem_resp
- d_pmem_wdata  in  LINE_WIDTH  L1D writeback data
- d_pmem_rdata  out  LINE_WIDTH  line data to L1D
- d_pmem_resp  out  1  one-cycle completion pulse to L1D
- l2_address  out  32  downstream address, latched at grant
- l2_read  out  1  downstream read request
- l2_write  out  1  downstream write request
- l2_wdata  out  LINE_WIDTH  downstream write data, latched at grant
- l2_rdata  in  LINE_WIDTH  downstream read data, valid with l2_resp
- l2_resp  in  1  downstream completion
- conflict_clear  in  1  synchronous clear of conflict_count
- conflict_count  out  32  number of arbitrations with both clients requesting

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE. The state register is 2 bits. A last_grant register holds 1 bit, with I or D.
- IDLE, I request = i_pmem_read. D request = d_pmem_read | d_pmem_write.
  - Only one client requesting: grant that client.
  - Both requesting: grant the client not equal to last_grant.
  - Neither requesting: stay in IDLE.
- On grant, at the same edge:
  - Latch the winner's address into l2_address.
  - Latch d_pmem_wdata into l2_wdata (D grants only).
  - Latch the operation. For D, write has priority if read and write are both high, and only l2_write is issued.
  - Set last_grant to the winner and move to SERVE_x.
- SERVE_x drives exactly one of l2_read or l2_write high, decoded from state plus the latched op. l2_address and l2_wdata stay stable for the whole state.
- In SERVE_x with l2_resp=1:
  - x_pmem_resp=1 in that same cycle, combinationally.
  - Next state is DONE.
- DONE: all request and response outputs are low, and the next state is IDLE. This bubble lets the client drop its request so it is not re-granted.
- i_pmem_rdata and d_pmem_rdata both equal l2_rdata at all times. Only x_pmem_resp qualifies the data.
- l2_resp is ignored in IDLE and DONE, and never forwarded.
- conflict_count increments by 1 on each IDLE grant where both clients were requesting.
  - It saturates at 0xFFFFFFFF.
  - conflict_clear has priority over increment, and the count reads 0 the cycle after clear.
- A client changing its address while in SERVE has no effect, because the address was latched.

## Timing
- Reset values: state=IDLE, last_grant=I (so the first tie goes to D), l2_read=0, l2_write=0, l2_address=0, l2_wdata=0, both resp=0, conflict_count=0.
- Request sampled in IDLE at edge T. l2_read or l2_write is high from cycle T+1.
- l2_resp seen in cycle N gives x_pmem_resp in cycle N (zero added latency on return). DONE is cycle N+1, IDLE is cycle N+2. The earliest next l2 request is in cycle N+3.
- Single-cycle l2_resp is required. The arbiter holds its request until l2_resp regardless of downstream latency.
- rst mid-transaction:
  - State returns to IDLE and all outputs reach reset values the next cycle.
  - The pending downstream transaction is abandoned, and a late l2_resp is ignored.
  - conflict_count clears.

## Test plan
- Lone I read, address 0x0000_1000, l2_resp after 5 cycles with rdata 0xA5.. repeated.
  - l2_read and l2_address=0x1000 from cycle 1.
  - i_pmem_resp=1 and i_pmem_rdata=0xA5.. in cycle 5.
  - No d_pmem_resp.
  - l2_read=0 in cycles 6-7.
- Simultaneous I read (0x100) and D read (0x200) from reset.
  - D is granted first, l2_address=0x200.
  - After d_pmem_resp and D dropping its request, I is granted with l2_address=0x100.
  - conflict_count=1.
- Repeated simultaneous requests with both clients re-requesting immediately after each resp.
  - Grants alternate D,I,D,I.
  - conflict_count increments on each grant.
- D with read and write both high, wdata=0xDEAD.., address 0x300.
  - Only l2_write=1, l2_wdata=0xDEAD.., l2_address=0x300.
  - d_pmem_resp on l2_resp.
- Reset asserted in SERVE_I before l2_resp.
  - Next cycle: l2_read=0, state IDLE, conflict_count=0.
  - l2_resp pulsed afterward yields no i_pmem_resp.
- conflict_count preloaded to 0xFFFFFFFF by forcing, then a conflict occurs: the count stays 0xFFFFFFFF. Then conflict_clear together with a conflict: the count is 0.
